mult_seq_param: RTL and testbench

//   Parametrised sequential shift-add multiplier, successor to the 16-bit

---
 rtl/mult_seq_param.sv | 134 +++++++++++++
 tb/tb_mult_seq_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// mult_seq_param: sequential shift-add multiplier, one multiplier bit per clock.
// Signed operands are reduced to magnitudes at start; the sign is
// re-applied to the final sum only, so the datapath is purely unsigned.
// The product s is written once per run and held until the next run completes.
module mult_seq_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     e1,
    input  logic [WIDTH-1:0]     e2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   s
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [PW-1:0]    P_ONE    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    P_ZERO   = {PW{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of an operand. In signed mode the most negative value maps to
    // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = ~v + W_ONE;
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t            state_r;
    logic              neg_r;
    logic [PW-1:0]     mcand_r;   // multiplicand, shifted left each iteration
    logic [WIDTH-1:0]  mplier_r;  // multiplier, shifted right each iteration
    logic [PW-1:0]     acc_r;
    logic [CW-1:0]     cnt_r;

    logic [PW-1:0]     acc_sum_s;
    logic [PW-1:0]     result_s;
    logic              last_iter_s;

    // Next accumulator value and the sign-corrected final product.
    always_comb begin
        acc_sum_s   = acc_r;
        result_s    = acc_r;
        last_iter_s = (cnt_r == CNT_LAST);
        if (mplier_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
        // Negating zero yields zero, so a zero operand never produces -0.
        if (neg_r) begin
            result_s = ~acc_sum_s + P_ONE;
        end else begin
            result_s = acc_sum_s;
        end
    end

    // Control FSM and datapath registers; reset aborts any run in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            neg_r    <= 1'b0;
            mcand_r  <= P_ZERO;
            mplier_r <= W_ZERO;
            acc_r    <= P_ZERO;
            cnt_r    <= CNT_ZERO;
            busy     <= 1'b0;
            done     <= 1'b0;
            s        <= P_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        neg_r    <= signed_mode & (e1[WIDTH-1] ^ e2[WIDTH-1]);
                        mcand_r  <= {W_ZERO, magnitude(e1, signed_mode)};
                        mplier_r <= magnitude(e2, signed_mode);
                        acc_r    <= P_ZERO;
                        cnt_r    <= CNT_ZERO;
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy     <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r    <= acc_sum_s;
                    mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (last_iter_s) begin
                        s       <= result_s;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done    <= 1'b0;
                    end
                end
                DONE: begin
                    // start is ignored here; the pulse lasts exactly one cycle.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param with a 16-bit and an 8-bit instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult_seq_param;

    logic        clk;
    logic        rst;

    logic        start16, sm16, busy16, done16;
    logic [15:0] e1_16, e2_16;
    logic [31:0] s16;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  e1_8, e2_8;
    logic [15:0] s8;

    int n_asserts;
    int n_fail;

    mult_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .e1(e1_16), .e2(e2_16), .busy(busy16), .done(done16), .s(s16)
    );

    mult_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .e1(e1_8), .e2(e2_8), .busy(busy8), .done(done8), .s(s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 16-bit transaction: latency, hold of s during RUN, busy, one-cycle done.
    task automatic run16(input string tag, input logic sm, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp);
        logic [31:0] s_before;
        int          waited;
        bit          held, busy_ok;
        @(negedge clk);
        start16 = 1'b1; sm16 = sm; e1_16 = a; e2_16 = b;
        s_before = s16;
        @(negedge clk);
        start16 = 1'b0;
        sm16 = 1'($urandom()); e1_16 = 16'($urandom()); e2_16 = 16'($urandom());
        waited = 0; held = 1'b1; busy_ok = 1'b1;
        while (done16 !== 1'b1 && waited < 40) begin
            if (s16 !== s_before) held = 1'b0;
            if (busy16 !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            waited++;
        end
        check({tag, "_latency"}, 32'(waited), 32'd16);
        check({tag, "_s"}, s16, exp);
        check({tag, "_busy_done"}, {31'd0, busy16}, 32'd1);
        check({tag, "_s_held"}, {31'd0, held}, 32'd1);
        check({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {30'd0, done16, busy16}, 32'd0);
        check({tag, "_s_kept"}, s16, exp);
    endtask

    // One 8-bit transaction.
    task automatic run8(input string tag, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
        int waited;
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; e1_8 = a; e2_8 = b;
        @(negedge clk);
        start8 = 1'b0;
        sm8 = 1'($urandom()); e1_8 = 8'($urandom()); e2_8 = 8'($urandom());
        waited = 0;
        while (done8 !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_latency"}, 32'(waited), 32'd8);
        check({tag, "_s"}, {16'd0, s8}, {16'd0, exp});
        @(negedge clk);
        check({tag, "_done_1cyc"}, {30'd0, done8, busy8}, 32'd0);
    endtask

    initial begin
        int          pulses;
        logic [31:0] s_at_done;
        logic [7:0]  ra, rb;
        logic [15:0] qa, qb;
        logic signed [15:0] ps8;
        logic signed [31:0] ps16;

        n_asserts = 0;
        n_fail    = 0;
        rst = 1'b1;
        start16 = 1'b0; sm16 = 1'b0; e1_16 = 16'd0; e2_16 = 16'd0;
        start8  = 1'b0; sm8  = 1'b0; e1_8  = 8'd0;  e2_8  = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset16", {s16[29:0], busy16, done16}, 32'd0);
        check("reset8", {14'd0, s8, busy8, done8}, 32'd0);
        rst = 1'b0;

        // Directed 16-bit vectors
        run16("u_basic",  1'b0, 16'h0296, 16'h01C3, 32'h00048E42);
        run16("u_ffff",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run16("s_ffff",   1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
        run16("s_m1x1",   1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF);
        run16("s_min2",   1'b1, 16'h8000, 16'h8000, 32'h40000000);
        run16("s_minmax", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
        run16("s_zero",   1'b1, 16'h0000, 16'h8000, 32'h00000000);
        run16("u_min2",   1'b0, 16'h8000, 16'h8000, 32'h40000000);

        // start re-pulsed during RUN and during DONE is ignored
        @(negedge clk);
        start16 = 1'b1; sm16 = 1'b0; e1_16 = 16'h1234; e2_16 = 16'h0010;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        start16 = 1'b1; e1_16 = 16'h0005; e2_16 = 16'h0003;
        pulses = 0;
        s_at_done = 32'd0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (done16 === 1'b1) begin
                pulses++;
                s_at_done = s16;
                start16 = 1'b1;
            end
        end
        start16 = 1'b0;
        check("repulse_count", 32'(pulses), 32'd1);
        check("repulse_s", s_at_done, 32'h00012340);
        check("repulse_idle", {31'd0, busy16}, 32'd0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start16 = 1'b1; sm16 = 1'b0; e1_16 = 16'h00FF; e2_16 = 16'h0101;
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy16}, 32'd0);
        check("arst_done", {31'd0, done16}, 32'd0);
        check("arst_s", s16, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done16 === 1'b1) pulses++;
        end
        check("arst_no_done", 32'(pulses), 32'd0);
        run16("after_rst", 1'b0, 16'd3, 16'd4, 32'd12);

        // 8-bit instance, directed
        run8("w8_s_min2", 1'b1, 8'h80, 8'h80, 16'h4000);
        run8("w8_u_ff",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8("w8_s_mm",   1'b1, 8'h80, 8'h7F, 16'hC080);
        run8("w8_s_m1",   1'b1, 8'hFF, 8'h03, 16'hFFFD);

        // Random sweep against the behavioural product, both modes
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom());
            rb = 8'($urandom());
            ps8 = $signed(ra) * $signed(rb);
            if (i[0]) run8("w8_rand_s", 1'b1, ra, rb, ps8);
            else      run8("w8_rand_u", 1'b0, ra, rb, {8'd0, ra} * {8'd0, rb});
        end
        for (int i = 0; i < 4; i++) begin
            qa = 16'($urandom());
            qb = 16'($urandom());
            ps16 = $signed(qa) * $signed(qb);
            if (i[0]) run16("w16_rand_s", 1'b1, qa, qb, ps16);
            else      run16("w16_rand_u", 1'b0, qa, qb, {16'd0, qa} * {16'd0, qb});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
